bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), processing one input bit per clock.
- Sits upstream of the BCD-to-seven-segment decoder: converts counter/ALU binary values into packed BCD digits for display.
- Uses a start/busy/done handshake. The result is held stable between conversions.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 135 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
   localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adj_c
);

   always_comb begin
      adj_c = digit;
      if (digit >= BCD_ADJ_THRESH) begin
         adj_c = digit + BCD_ADJ_ADD;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank mask output when LEAD_ZERO_BLANK_EN is defined.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
`ifdef LEAD_ZERO_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   scr_q, scr_d;
   logic [BCD_W-1:0]   adj_c;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               shift_out;
   logic               busy_d, done_d;
   logic [BCD_W-1:0]   bcd_d;
   logic               ovf_d;

   // Per-digit add-3 correction applied before every shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_add3 u_add3 (
         .digit (scr_q[4*g +: 4]),
         .adj_c (adj_c[4*g +: 4])
      );
   end

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scr_d     = scr_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      shift_out = 1'b0;
      bcd_d     = bcd_out;
      ovf_d     = overflow;

      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin_in;
               scr_d   = '0;
               cnt_d   = '0;
               carry_d = 1'b0;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            // Any bit leaving the top digit means the value exceeds DIGITS digits.
            {shift_out, scr_d, bin_d} = {adj_c, bin_q, 1'b0};
            carry_d = carry_q | shift_out;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               bcd_d   = scr_d;
               ovf_d   = carry_d;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == CONVERT);
      done_d = (state_d == DONE);
   end

`ifdef LEAD_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_d;
   logic              hi_zero;

   // Blank digit i when it and every digit above it are zero; units never blanked.
   always_comb begin
      blank_d = '0;
      hi_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         hi_zero    = hi_zero & (bcd_d[4*i +: 4] == 4'd0);
         blank_d[i] = hi_zero;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else begin
         blank <= blank_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         bin_q    <= '0;
         scr_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd_out  <= '0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         scr_q    <= scr_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         busy     <= busy_d;
         done     <= done_d;
         bcd_out  <= bcd_d;
         overflow <= ovf_d;
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: 16-bit/5-digit and 8-bit/2-digit instances.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] bin_in;
   logic        busy, done, overflow;
   logic [19:0] bcd_out;
   logic        start8;
   logic [7:0]  bin8;
   logic        busy8, done8, ovf8;
   logic [7:0]  bcd8;
`ifdef LEAD_ZERO_BLANK_EN
   logic [4:0]  blank;
   logic [1:0]  blank8;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
      .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
`ifdef LEAD_ZERO_BLANK_EN
      , .blank(blank)
`endif
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .bin_in(bin8),
      .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8)
`ifdef LEAD_ZERO_BLANK_EN
      , .blank(blank8)
`endif
   );

   // Reference: decimal digits by repeated division, digit 0 = units.
   function automatic logic [19:0] ref_bcd5(input int unsigned v);
      int unsigned t = v;
      logic [19:0] r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] ref_bcd2(input int unsigned v);
      return {4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [4:0] ref_blank(input int unsigned v);
      logic [4:0] b = '0;
      int unsigned p = 10;
      for (int i = 1; i < 5; i++) begin
         b[i] = (v < p);
         p = p * 10;
      end
      return b;
   endfunction

   // Runs one conversion on the 16-bit instance and reports what was observed.
   task automatic convert16(input logic [15:0] v, input bit chg,
                            output int busy_cnt, output int lat,
                            output logic [19:0] res, output logic ovf,
                            output logic done_after);
      busy_cnt = 0; lat = 0; res = 'x; ovf = 1'bx; done_after = 1'bx;
      @(negedge clk);
      start = 1'b1; bin_in = v;
      @(posedge clk);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 0 && chg) bin_in = 16'd999;
         if (busy) busy_cnt++;
         if (done) begin
            lat = n + 1; res = bcd_out; ovf = overflow;
            break;
         end
      end
      @(negedge clk);
      done_after = done;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; bin_in = '0; start8 = 1'b0; bin8 = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (bcd_out !== 20'h0) begin n_bad++; $display("FAIL reset_bcd got %h want 0", bcd_out); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
`ifdef LEAD_ZERO_BLANK_EN
      n_cmp++; if (blank !== 5'b11110) begin n_bad++; $display("FAIL reset_blank got %b want 11110", blank); end
`endif
      reset = 1'b0;
   endtask

   task automatic test_convert(input logic [15:0] v, input string name);
      int bc, lat; logic [19:0] res; logic ovf, da;
      convert16(v, 1'b0, bc, lat, res, ovf, da);
      n_cmp++; if (res !== ref_bcd5(v)) begin n_bad++; $display("FAIL %s_bcd in=%0d got %h want %h", name, v, res, ref_bcd5(v)); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL %s_ovf in=%0d got %b want 0", name, v, ovf); end
      n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL %s_latency got %0d want 17", name, lat); end
      n_cmp++; if (bc !== 16) begin n_bad++; $display("FAIL %s_busy_cycles got %0d want 16", name, bc); end
      n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL %s_done_width got %b want 0", name, da); end
      n_cmp++; if (bcd_out !== ref_bcd5(v)) begin n_bad++; $display("FAIL %s_hold got %h want %h", name, bcd_out, ref_bcd5(v)); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) test_convert(16'($urandom_range(65535, 0)), "random");
   endtask

   task automatic test_bin_change();
      int bc, lat; logic [19:0] res; logic ovf, da;
      convert16(16'd100, 1'b1, bc, lat, res, ovf, da);
      n_cmp++; if (res !== 20'h00100) begin n_bad++; $display("FAIL bin_change got %h want 00100", res); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [4];
      int d_cyc [3];
      int j = 0;
      for (int i = 0; i < 4; i++) vals[i] = 16'($urandom_range(65535, 0));
      @(negedge clk);
      bin_in = vals[0]; start = 1'b1;
      for (int c = 0; c < 120 && j < 3; c++) begin
         @(negedge clk);
         if (done) begin
            d_cyc[j] = c;
            n_cmp++; if (bcd_out !== ref_bcd5(vals[j])) begin n_bad++; $display("FAIL b2b_bcd%0d got %h want %h", j, bcd_out, ref_bcd5(vals[j])); end
            j++;
            bin_in = vals[j];
            if (j == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      n_cmp++; if (j !== 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", j); end
      if (j == 3) begin
         n_cmp++; if (d_cyc[1] - d_cyc[0] !== 18) begin n_bad++; $display("FAIL b2b_period0 got %0d want 18", d_cyc[1] - d_cyc[0]); end
         n_cmp++; if (d_cyc[2] - d_cyc[1] !== 18) begin n_bad++; $display("FAIL b2b_period1 got %0d want 18", d_cyc[2] - d_cyc[1]); end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int bc, lat; logic [19:0] res; logic ovf, da;
      logic seen = 1'b0;
      @(negedge clk);
      start = 1'b1; bin_in = 16'd4321;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
      n_cmp++; if (bcd_out !== 20'h0) begin n_bad++; $display("FAIL midrst_bcd got %h want 0", bcd_out); end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", seen); end
      convert16(16'd4321, 1'b0, bc, lat, res, ovf, da);
      n_cmp++; if (res !== 20'h04321) begin n_bad++; $display("FAIL midrst_rerun got %h want 04321", res); end
   endtask

   task automatic test_overflow();
      int unsigned vals [6];
      vals[0] = 200; vals[1] = 99; vals[2] = 100; vals[3] = 255;
      vals[4] = $urandom_range(255, 0); vals[5] = $urandom_range(99, 0);
      for (int i = 0; i < 6; i++) begin
         int lat = 0;
         @(negedge clk);
         start8 = 1'b1; bin8 = 8'(vals[i]);
         @(posedge clk);
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin lat = n + 1; break; end
         end
         n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL ovf8_latency in=%0d got %0d want 9", vals[i], lat); end
         n_cmp++; if (bcd8 !== ref_bcd2(vals[i])) begin n_bad++; $display("FAIL ovf8_bcd in=%0d got %h want %h", vals[i], bcd8, ref_bcd2(vals[i])); end
         n_cmp++; if (ovf8 !== (vals[i] > 99)) begin n_bad++; $display("FAIL ovf8_flag in=%0d got %b want %b", vals[i], ovf8, vals[i] > 99); end
         @(negedge clk);
      end
   endtask

`ifdef LEAD_ZERO_BLANK_EN
   task automatic test_blank();
      int unsigned vals [4];
      int bc, lat; logic [19:0] res; logic ovf, da;
      vals[0] = 1234; vals[1] = 7; vals[2] = 0; vals[3] = $urandom_range(65535, 0);
      for (int i = 0; i < 4; i++) begin
         convert16(16'(vals[i]), 1'b0, bc, lat, res, ovf, da);
         n_cmp++; if (blank !== ref_blank(vals[i])) begin n_bad++; $display("FAIL blank in=%0d got %b want %b", vals[i], blank, ref_blank(vals[i])); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_convert(16'd0, "zero");
      test_convert(16'd65535, "max");
      test_random();
      test_bin_change();
      test_back_to_back();
      test_reset_mid();
      test_overflow();
`ifdef LEAD_ZERO_BLANK_EN
      test_blank();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
